// File: rtl/lcrc_pkg.sv
// Shared types and constants for the LCRC transmit sequencer.
package lcrc_pkg;

    localparam int          SEQ_W      = 12;
    localparam logic [11:0] SEQ_MAX    = 12'd4095;
    localparam logic [31:0] LCRC_POLY  = 32'hEDB88320;
    localparam logic [31:0] LCRC_SEED  = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEQ_HI  = 3'd1,
        SEQ_LO  = 3'd2,
        PAYLOAD = 3'd3,
        CRC0    = 3'd4,
        CRC1    = 3'd5,
        CRC2    = 3'd6,
        CRC3    = 3'd7
    } lcrc_state_e;

endpackage

// File: rtl/lcrc_byte_engine.sv
// Combinational reflected CRC-32 step: folds one byte, LSB first, into crc_i.
module lcrc_byte_engine
    import lcrc_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    // Eight serial shift/xor steps unrolled into one combinational cone.
    always_comb begin
        c = crc_i;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data_i[i]) c = (c >> 1) ^ LCRC_POLY;
            else                  c = c >> 1;
        end
        crc_o = c;
    end

endmodule

// File: rtl/lcrc_tx_ctrl.sv
// Transmit sequencer: prepends the 12-bit sequence header to a TLP byte
// stream and appends the 4-byte LCRC, LSB first, through one output slot.
// Optional feature: define LCRC_TX_NULLIFY_EN to add in_nullify, which sends
// the un-complemented CRC and leaves next_seq unchanged.
module lcrc_tx_ctrl
    import lcrc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SEQ_W = lcrc_pkg::SEQ_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
`ifdef LCRC_TX_NULLIFY_EN
    input  logic             in_nullify,
`endif
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [SEQ_W-1:0] next_seq,
    output logic             tlp_done
);

    lcrc_state_e      state_q, state_d;
    logic [31:0]      crc_q, crc_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [7:0]       odata_q, odata_d;
    logic             ovld_q, ovld_d;
    logic             olast_q, olast_d;
    logic             done_q, done_d;
    logic             nul_q, nul_d;

    logic             free;
    logic [7:0]       eng_byte;
    logic [31:0]      eng_crc;
    logic [31:0]      crc_fin;

    assign free = !ovld_q || out_ready;

`ifdef LCRC_TX_NULLIFY_EN
    assign crc_fin = nul_q ? crc_q : ~crc_q;
`else
    assign crc_fin = ~crc_q;
`endif

    // Select which byte the CRC engine folds this cycle: header or payload.
    always_comb begin
        eng_byte = in_data;
        case (state_q)
            SEQ_HI:  eng_byte = {4'b0, seq_q[11:8]};
            SEQ_LO:  eng_byte = seq_q[7:0];
            default: eng_byte = in_data;
        endcase
    end

    lcrc_byte_engine u_eng (
        .crc_i  (crc_q),
        .data_i (eng_byte),
        .crc_o  (eng_crc)
    );

    // Next-state, slot loading and CRC/sequence update.
    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        seq_d    = seq_q;
        odata_d  = odata_q;
        ovld_d   = ovld_q;
        olast_d  = olast_q;
        done_d   = 1'b0;
        nul_d    = nul_q;
        in_ready = 1'b0;
        // A free slot drains unless something is loaded below.
        if (free) begin
            ovld_d  = 1'b0;
            olast_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                crc_d = LCRC_SEED;
                nul_d = 1'b0;
                if (in_valid && free) state_d = SEQ_HI;
            end
            SEQ_HI, SEQ_LO: begin
                if (free) begin
                    odata_d = eng_byte;
                    ovld_d  = 1'b1;
                    crc_d   = eng_crc;
                    state_d = (state_q == SEQ_HI) ? SEQ_LO : PAYLOAD;
                end
            end
            PAYLOAD: begin
                in_ready = free;
                if (free && in_valid) begin
                    odata_d = eng_byte;
                    ovld_d  = 1'b1;
                    crc_d   = eng_crc;
                    if (in_last) begin
                        state_d = CRC0;
`ifdef LCRC_TX_NULLIFY_EN
                        nul_d   = in_nullify;
`endif
                    end
                end
            end
            CRC0, CRC1, CRC2: begin
                if (free) begin
                    ovld_d = 1'b1;
                    case (state_q)
                        CRC0:    begin odata_d = crc_fin[7:0];   state_d = CRC1; end
                        CRC1:    begin odata_d = crc_fin[15:8];  state_d = CRC2; end
                        default: begin odata_d = crc_fin[23:16]; state_d = CRC3; end
                    endcase
                end
            end
            CRC3: begin
                // First visit loads the final byte; then wait for its handshake.
                if (olast_q) begin
                    if (out_ready) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        if (!nul_q) seq_d = seq_q + 1'b1;
                    end
                end else if (free) begin
                    odata_d = crc_fin[31:24];
                    ovld_d  = 1'b1;
                    olast_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            crc_q   <= LCRC_SEED;
            seq_q   <= '0;
            odata_q <= '0;
            ovld_q  <= 1'b0;
            olast_q <= 1'b0;
            done_q  <= 1'b0;
            nul_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            seq_q   <= seq_d;
            odata_q <= odata_d;
            ovld_q  <= ovld_d;
            olast_q <= olast_d;
            done_q  <= done_d;
            nul_q   <= nul_d;
        end
    end

    assign out_data  = odata_q;
    assign out_valid = ovld_q;
    assign out_last  = olast_q;
    assign next_seq  = seq_q;
    assign tlp_done  = done_q;

endmodule

// File: tb/tb_lcrc_tx_ctrl.sv
// Randomized bench for lcrc_tx_ctrl with a table-driven CRC-32 reference model.
module tb_lcrc_tx_ctrl;
    import lcrc_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready = 1'b1;
    logic [11:0] next_seq;
    logic        tlp_done;
`ifdef LCRC_TX_NULLIFY_EN
    logic        in_nullify = 1'b0;
`endif

    lcrc_tx_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
`ifdef LCRC_TX_NULLIFY_EN
        .in_nullify (in_nullify),
`endif
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .next_seq   (next_seq),
        .tlp_done   (tlp_done)
    );

    logic [31:0] ecrc, ecrc_nx;
    logic [7:0]  edata;
    lcrc_byte_engine u_eng_ut (.crc_i(ecrc), .data_i(edata), .crc_o(ecrc_nx));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: byte-wise table CRC-32 and a plain integer sequence counter.
    logic [31:0] crc_tab [256];
    int          model_seq = 0;

    function automatic logic [31:0] model_f(input logic [7:0] fr[$], input bit nul);
        logic [31:0] c = 32'hFFFFFFFF;
        foreach (fr[i]) c = crc_tab[8'(c ^ 32'(fr[i]))] ^ (c >> 8);
        return nul ? c : ~c;
    endfunction

    // Output readiness generator: 0 always ready, 1 one-in-three, 2 random.
    int rdy_mode = 0;
    int cyc = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        cyc++;
    end

    // Monitor samples at the falling edge, half a cycle away from updates.
    logic [7:0] rx_q[$];
    int last_cnt = 0, last_pos = 0, done_cnt = 0, viol = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                rx_q.push_back(out_data);
                if (out_last) begin
                    last_cnt++;
                    last_pos = rx_q.size();
                end
            end
            if (in_ready && out_valid && !out_ready) viol++;
            if (tlp_done) done_cnt++;
        end
    end

    task automatic send_tlp(input logic [7:0] pl[$], input bit nul);
        logic [7:0] fr[$];
        logic [7:0] expq[$];
        logic [31:0] f;
        int n;
        logic [11:0] s;
        s = 12'(model_seq);
        rx_q.delete();
        last_cnt = 0; last_pos = 0; done_cnt = 0;
        foreach (pl[i]) begin
            in_valid = 1'b1;
            in_data  = pl[i];
            in_last  = (i == pl.size() - 1);
`ifdef LCRC_TX_NULLIFY_EN
            in_nullify = nul;
`endif
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 300) begin n++; @(negedge clk); end
            if (n >= 300) begin
                chk("in_ready_wait", 0, 1);
                in_valid = 1'b0; in_last = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("done_wait", 0, 1);
        repeat (3) @(negedge clk);
        // Expected frame from the rules: header, payload, final CRC LSB first.
        fr.push_back({4'b0, s[11:8]});
        fr.push_back(s[7:0]);
        foreach (pl[i]) fr.push_back(pl[i]);
`ifdef LCRC_TX_NULLIFY_EN
        f = model_f(fr, nul);
`else
        f = model_f(fr, 1'b0);
`endif
        expq = fr;
        for (int k = 0; k < 4; k++) expq.push_back(f[8*k +: 8]);
        chk("frame_len", rx_q.size(), expq.size());
        for (int k = 0; k < expq.size() && k < rx_q.size(); k++)
            chk($sformatf("byte%0d", k), rx_q[k], expq[k]);
        chk("last_cnt", last_cnt, 1);
        chk("last_pos", last_pos, expq.size());
        chk("done_cnt", done_cnt, 1);
`ifdef LCRC_TX_NULLIFY_EN
        if (!nul) model_seq = (model_seq + 1) % 4096;
`else
        model_seq = (model_seq + 1) % 4096;
`endif
        chk("next_seq", next_seq, model_seq);
    endtask

    task automatic rand_tlp(input int len, input bit nul);
        logic [7:0] pl[$];
        repeat (len) pl.push_back(8'($urandom));
        send_tlp(pl, nul);
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_out_valid"}, out_valid, 0);
        chk({pfx, "_out_last"},  out_last, 0);
        chk({pfx, "_out_data"},  out_data, 0);
        chk({pfx, "_in_ready"},  in_ready, 0);
        chk({pfx, "_tlp_done"},  tlp_done, 0);
        chk({pfx, "_next_seq"},  next_seq, 0);
    endtask

    initial begin
        logic [7:0]  pl[$];
        logic [31:0] c;
        string       s;
        int          n;
        for (int i = 0; i < 256; i++) begin
            c = 32'(i);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #2;
        chk_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;

        // Engine check value.
        s = "123456789";
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) begin
            ecrc = c; edata = s[i]; #1;
            c = ecrc_nx;
        end
        chk("engine_check", ~c, 32'hCBF43926);

        // Single-byte TLP with out_ready held high.
        @(posedge clk); #1;
        pl.delete(); pl.push_back(8'h55);
        send_tlp(pl, 1'b0);

        // One-in-three backpressure over 16 bytes.
        rdy_mode = 1;
        viol = 0;
        rand_tlp(16, 1'b0);
        chk("ready_while_full", viol, 0);

        // Random lengths and random backpressure.
        rdy_mode = 2;
        for (int t = 0; t < 6; t++) rand_tlp($urandom_range(1, 12), 1'b0);
        chk("ready_while_full_rand", viol, 0);

`ifdef LCRC_TX_NULLIFY_EN
        rdy_mode = 2;
        rand_tlp(5, 1'b1);
        rand_tlp(3, 1'b0);
`endif

        // Reset mid-payload after 5 accepted bytes.
        rdy_mode = 0;
        @(posedge clk); #1;
        n = 0;
        in_valid = 1'b1; in_last = 1'b0;
        while (n < 5) begin
            in_data = 8'($urandom);
            @(negedge clk);
            if (in_ready) n++;
            @(posedge clk); #1;
        end
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        in_valid = 1'b0;
        model_seq = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        rand_tlp(4, 1'b0);

        // Run the counter up to 4095, then check the wrap TLP.
        while (model_seq != 4095) rand_tlp(1, 1'b0);
        rand_tlp(2, 1'b0);
        if (rx_q.size() >= 2) begin
            chk("wrap_hdr_hi", rx_q[0], 8'h0F);
            chk("wrap_hdr_lo", rx_q[1], 8'hFF);
        end else chk("wrap_frame_len", rx_q.size(), 8);
        chk("wrap_next_seq", next_seq, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
